// File: rtl/hazard_unit.sv
// Hazard detection and operand forwarding for the 5-stage MIPS pipeline, with
// multiply (HI/LO) occupancy tracking and saturating stall/flush event counters.
module hazard_unit #(
    parameter int         MUL_LAT  = 4,
    parameter logic [1:0] LOAD_SEL = 2'b01,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rsd,
    input  logic [4:0]       rtd,
    input  logic             branch_d,
    input  logic             jr_d,
    input  logic             hilo_rd_d,
    input  logic             hilo_we_d,
    input  logic [4:0]       rse,
    input  logic [4:0]       rte,
    input  logic [4:0]       rf_wae,
    input  logic             we_rege,
    input  logic [1:0]       dm2rege,
    input  logic             hilo_we_e,
    input  logic [4:0]       rf_wam,
    input  logic             we_regm,
    input  logic [1:0]       dm2regm,
    input  logic [4:0]       rf_waw,
    input  logic             we_regw,
    input  logic             cnt_clr,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_e,
    output logic             forward_ad,
    output logic             forward_bd,
    output logic [1:0]       forward_ae,
    output logic [1:0]       forward_be,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [3:0]       MUL_LOAD = 4'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [3:0] mcnt;
    logic       lw_stall;
    logic       br_stall;
    logic       hl_stall;
    logic       stall;
    logic       e_hit_d;
    logic       m_load_hit_d;

    // MEM-stage result is newer than WB, so it wins when both match.
    always_comb begin
        forward_ae = 2'b00;
        if (rse != 5'd0 && we_regm && rse == rf_wam)
            forward_ae = 2'b10;
        else if (rse != 5'd0 && we_regw && rse == rf_waw)
            forward_ae = 2'b01;

        forward_be = 2'b00;
        if (rte != 5'd0 && we_regm && rte == rf_wam)
            forward_be = 2'b10;
        else if (rte != 5'd0 && we_regw && rte == rf_waw)
            forward_be = 2'b01;
    end

    assign forward_ad = (rsd != 5'd0) && we_regm && (rsd == rf_wam);
    assign forward_bd = (rtd != 5'd0) && we_regm && (rtd == rf_wam);

    // Branch/jr compare in decode, so even an ALU result still in E is too late,
    // and a load in M has no value on the alu_outm bypass yet.
    assign e_hit_d      = we_rege && (rf_wae != 5'd0) && (rf_wae == rsd || rf_wae == rtd);
    assign m_load_hit_d = we_regm && (dm2regm == LOAD_SEL) && (rf_wam != 5'd0)
                          && (rf_wam == rsd || rf_wam == rtd);

    assign lw_stall = we_rege && (dm2rege == LOAD_SEL) && (rf_wae != 5'd0)
                      && (rf_wae == rsd || rf_wae == rtd);
    assign br_stall = (branch_d || jr_d) && (e_hit_d || m_load_hit_d);
    assign hl_stall = (hilo_rd_d || hilo_we_d) && (mul_busy || hilo_we_e);
    assign stall    = lw_stall || br_stall || hl_stall;

    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_e = stall;

    // A new HI/LO write is only accepted once the previous countdown is done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mcnt <= 4'd0;
        else if (hilo_we_e && mcnt == 4'd0)
            mcnt <= MUL_LOAD;
        else if (mcnt != 4'd0)
            mcnt <= mcnt - 4'd1;
    end

    assign mul_busy = (mcnt != 4'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_d && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_e && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
